robo_cmd_arbiter: RTL
=====================

// Module: robo_cmd_arbiter
// PURPOSE
//  Arbitrates and paces movement commands for the maze robot core (Memo).
//  Two requesters share the robot's avancar/girar/remover command inputs: the
//  gamepad (manual mode) and the autonomous wall-follower (auto mode).
//  Issues at most one command per step. Each command is a single-cycle pulse,
//  followed by a settle window, a sensor snapshot and a completion pulse.
//  Owns flag_mode, which the gamepad MODE button toggles.
// PARAMETERS
//  STEP_CYCLES  4   settle cycles after a command pulse before sensors are sampled (>=1)
//  BIT_MODE     11  gamepad_input bit index of the MODE button
//  BIT_FWD      0   gamepad_input bit index of the forward button
//  BIT_TURN     1   gamepad_input bit index of the turn button
//  BIT_REMOVE   2   gamepad_input bit index of the remove button
// PORTS
//  clock          in   1   system clock; all logic on the rising edge
//  reset          in   1   synchronous, active-high
//  gamepad_input  in   12  raw button levels, 1 = pressed
//  auto_valid     in   1   autonomous requester has a command
//  auto_cmd       in   2   00 NOP(sense only), 01 avancar, 10 girar, 11 remover
//  auto_ready     out  1   command accepted when auto_valid && auto_ready
//  head_in        in   1   Memo head_out (wall ahead)
//  left_in        in   1   Memo left_out
//  under_in       in   1   Memo under_out
//  barrier_in     in   1   Memo barrier_out
//  avancar        out  1   one-cycle advance pulse to Memo
//  girar          out  1   one-cycle turn pulse to Memo
//  remover        out  1   one-cycle remove pulse to Memo
//  flag_mode      out  1   0 = auto, 1 = manual
//  busy           out  1   high in every state except IDLE
//  cmd_done       out  1   one-cycle pulse; command finished, sense_out valid
//  cmd_blocked    out  1   valid with cmd_done; avancar was suppressed
//  sense_out      out  4   {head,left,under,barrier}, latched in SAMPLE
// BEHAVIOUR
//  Reset: state=IDLE; flag_mode, avancar, girar, remover, busy, cmd_done and
//   cmd_blocked are 0; sense_out=0; settle counter=0; button-history regs=0.
//   A reset asserted mid-command aborts it. No pulse or cmd_done follows the reset.
//  Edge detect: all gamepad bits are registered every cycle. press = in & ~prev.
//   Held buttons generate no repeats.
//  Mode: press[BIT_MODE] toggles flag_mode on the next edge, in any state.
//   An in-flight command completes normally.
//   The new source is considered only from the next IDLE cycle.
//  auto_ready = (state==IDLE) && !flag_mode && !reset (combinational).
//  Manual accept: in IDLE with flag_mode=1, any press of FWD/TURN/REMOVE is taken.
//   Priority is FWD > TURN > REMOVE; other simultaneous presses are dropped.
//   Presses that arrive while busy are dropped, not queued.
//  Auto requests are ignored while flag_mode=1. Manual buttons are ignored while flag_mode=0.
//  FSM: IDLE -> ISSUE -> SETTLE -> SAMPLE -> IDLE
//   IDLE:   on accept, latch cmd (2b) and go to ISSUE. busy=0.
//   ISSUE:  exactly one cycle. Drive the pulse for the latched cmd.
//           If cmd=avancar and head_in=1, suppress the pulse and set blocked.
//           NOP drives no pulse. Load counter=STEP_CYCLES and go to SETTLE.
//   SETTLE: decrement the counter each cycle; go to SAMPLE on the cycle it reaches 1.
//   SAMPLE: sense_out<={head_in,left_in,under_in,barrier_in}; cmd_done=1;
//           cmd_blocked=blocked. Go to IDLE.
//  Latency: accept at edge N. Pulse high during cycle N+1. cmd_done high during
//   cycle N+2+STEP_CYCLES. Next accept is possible at the following edge.
//   Throughput is one command per STEP_CYCLES+3 cycles.
//  Pulse outputs, cmd_done and cmd_blocked are registered, mutually exclusive
//   and never high more than one cycle.
//  The counter is $clog2(STEP_CYCLES+1) bits wide and never wraps.
//  sense_out holds its value until the next SAMPLE.
// TESTING
//  1 reset 2 cycles, then auto_valid=1, auto_cmd=01, head_in=0 -> auto_ready=1 in IDLE;
//    avancar=1 exactly 1 cycle after accept; cmd_done 6 cycles after accept; cmd_blocked=0
//  2 auto_cmd=01 with head_in=1 -> no avancar pulse; cmd_done with cmd_blocked=1;
//    sense_out[3]=1
//  3 gamepad 12'h800 for 1 cycle -> flag_mode 0->1, auto_ready=0;
//    then 12'h003 -> single avancar pulse, no girar; holding 12'h003 gives no repeat
//  4 MODE press during SETTLE of an auto girar -> girar command completes with cmd_done;
//    flag_mode=1 on the next edge; auto_valid held high is not accepted afterwards
//  5 reset for 1 cycle during SETTLE -> busy=0, flag_mode=0, no cmd_done;
//    a new auto command is accepted normally
//  6 auto_cmd=00 NOP with sensors 4'b0110 -> no pulses; cmd_done and sense_out=4'b0110

Source files
------------

// File: rtl/robo_cmd_arbiter_if.sv
// Command/sensor bundle between the robot command arbiter and its surroundings:
// gamepad and autonomous requesters on one side, the Memo core on the other.
interface robo_cmd_arbiter_if;
    logic [11:0] gamepad_input;
    logic        auto_valid;
    logic [1:0]  auto_cmd;
    logic        auto_ready;
    logic        head_in;
    logic        left_in;
    logic        under_in;
    logic        barrier_in;
    logic        avancar;
    logic        girar;
    logic        remover;
    logic        flag_mode;
    logic        busy;
    logic        cmd_done;
    logic        cmd_blocked;
    logic [3:0]  sense_out;

    modport master (
        output gamepad_input, auto_valid, auto_cmd,
        output head_in, left_in, under_in, barrier_in,
        input  auto_ready, avancar, girar, remover,
        input  flag_mode, busy, cmd_done, cmd_blocked, sense_out
    );

    modport slave (
        input  gamepad_input, auto_valid, auto_cmd,
        input  head_in, left_in, under_in, barrier_in,
        output auto_ready, avancar, girar, remover,
        output flag_mode, busy, cmd_done, cmd_blocked, sense_out
    );
endinterface

// File: rtl/robo_cmd_arbiter.sv
// Movement command arbiter for the Memo maze robot. Chooses between gamepad
// (manual) and wall-follower (auto) requests, issues one single-cycle command
// pulse per step, waits a settle window, snapshots the sensors and signals
// completion. Owns the auto/manual mode flag toggled by the MODE button.
module robo_cmd_arbiter #(
    parameter int STEP_CYCLES = 4,
    parameter int BIT_MODE    = 11,
    parameter int BIT_FWD     = 0,
    parameter int BIT_TURN    = 1,
    parameter int BIT_REMOVE  = 2
) (
    input  logic              clock,
    input  logic              reset,
    robo_cmd_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(STEP_CYCLES + 1);

    localparam logic [1:0] CMD_NOP    = 2'b00;
    localparam logic [1:0] CMD_FWD    = 2'b01;
    localparam logic [1:0] CMD_TURN   = 2'b10;
    localparam logic [1:0] CMD_REMOVE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_SAMPLE = 2'd3
    } state_t;

    state_t           state_r;
    logic [11:0]      btn_prev_r;
    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       cmd_r;
    logic             blocked_r;
    logic             flag_mode_r;
    logic             busy_r;
    logic             avancar_r;
    logic             girar_r;
    logic             remover_r;
    logic             cmd_done_r;
    logic             cmd_blocked_r;
    logic [3:0]       sense_r;

    logic [11:0]      press_s;
    logic             auto_ready_s;
    logic             manual_hit_s;
    logic [1:0]       manual_cmd_s;
    logic             accept_s;
    logic [1:0]       accept_cmd_s;
    logic             unused_press_s;

    // Rising edges of the buttons; a held button produces a single press.
    assign press_s        = bus.gamepad_input & ~btn_prev_r;
    // Buttons without a function here are folded away on purpose.
    assign unused_press_s = ^press_s;
    assign auto_ready_s   = (state_r == ST_IDLE) && !flag_mode_r && !reset;

    assign bus.auto_ready  = auto_ready_s;
    assign bus.avancar     = avancar_r;
    assign bus.girar       = girar_r;
    assign bus.remover     = remover_r;
    assign bus.flag_mode   = flag_mode_r;
    assign bus.busy        = busy_r;
    assign bus.cmd_done    = cmd_done_r;
    assign bus.cmd_blocked = cmd_blocked_r;
    assign bus.sense_out   = sense_r;

    // Pick the manual command by fixed priority and select the active source.
    always_comb begin
        manual_hit_s = 1'b0;
        manual_cmd_s = CMD_NOP;
        accept_s     = 1'b0;
        accept_cmd_s = CMD_NOP;
        if (press_s[BIT_FWD]) begin
            manual_hit_s = 1'b1;
            manual_cmd_s = CMD_FWD;
        end else if (press_s[BIT_TURN]) begin
            manual_hit_s = 1'b1;
            manual_cmd_s = CMD_TURN;
        end else if (press_s[BIT_REMOVE]) begin
            manual_hit_s = 1'b1;
            manual_cmd_s = CMD_REMOVE;
        end else begin
            manual_hit_s = 1'b0;
            manual_cmd_s = CMD_NOP;
        end
        if (state_r != ST_IDLE) begin
            accept_s     = 1'b0;
            accept_cmd_s = CMD_NOP;
        end else if (flag_mode_r) begin
            accept_s     = manual_hit_s;
            accept_cmd_s = manual_cmd_s;
        end else begin
            accept_s     = bus.auto_valid;
            accept_cmd_s = bus.auto_cmd;
        end
    end

    // Command FSM with mode flag, button history and all registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            btn_prev_r    <= 12'h000;
            cnt_r         <= '0;
            cmd_r         <= CMD_NOP;
            blocked_r     <= 1'b0;
            flag_mode_r   <= 1'b0;
            busy_r        <= 1'b0;
            avancar_r     <= 1'b0;
            girar_r       <= 1'b0;
            remover_r     <= 1'b0;
            cmd_done_r    <= 1'b0;
            cmd_blocked_r <= 1'b0;
            sense_r       <= 4'b0000;
        end else begin
            btn_prev_r    <= bus.gamepad_input;
            avancar_r     <= 1'b0;
            girar_r       <= 1'b0;
            remover_r     <= 1'b0;
            cmd_done_r    <= 1'b0;
            cmd_blocked_r <= 1'b0;
            if (press_s[BIT_MODE]) begin
                flag_mode_r <= ~flag_mode_r;
            end
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        cmd_r   <= accept_cmd_s;
                        busy_r  <= 1'b1;
                        state_r <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    case (cmd_r)
                        CMD_FWD:    avancar_r <= !bus.head_in;
                        CMD_TURN:   girar_r   <= 1'b1;
                        CMD_REMOVE: remover_r <= 1'b1;
                        default:    avancar_r <= 1'b0;
                    endcase
                    blocked_r <= (cmd_r == CMD_FWD) && bus.head_in;
                    cnt_r     <= CNT_W'(STEP_CYCLES);
                    state_r   <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    // Stop at 1 so the counter never wraps below zero.
                    if (cnt_r <= CNT_W'(1)) begin
                        state_r <= ST_SAMPLE;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_SAMPLE: begin
                    sense_r       <= {bus.head_in, bus.left_in, bus.under_in, bus.barrier_in};
                    cmd_done_r    <= 1'b1;
                    cmd_blocked_r <= blocked_r;
                    busy_r        <= 1'b0;
                    state_r       <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
